// File: rtl/cache_control_pkg.sv
// Shared types and sizing for the 2-way set-associative L1 cache controller.
package cache_control_pkg;

  localparam int NUM_SETS = 8;
  localparam int NUM_WAYS = 2;
  localparam int INDEX_W  = $clog2(NUM_SETS);

  typedef logic [8:0]         cache_tag;
  typedef logic [INDEX_W-1:0] cache_index;
  typedef logic [3:0]         cache_offset;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } cache_ctrl_state_t;

endpackage

// File: rtl/cache_control_lru.sv
// Per-set LRU bit array: each bit names the way to evict next in that set.
module cache_lru
  import cache_control_pkg::*;
#(
  parameter int SETS = NUM_SETS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               load,
  input  logic               value,
  output logic               lru
);

  logic [SETS-1:0] bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else if (load) begin
      bits[index] <= value;
    end
  end

  assign lru = bits[index];

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way L1 cache: hit service, dirty writeback, line allocate.
module cache_control
  import cache_control_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  input  logic [INDEX_W-1:0] index,
  input  logic               hit,
  input  logic               compare0,
  input  logic               compare1,
  input  logic               valid0,
  input  logic               valid1,
  input  logic               dirty0,
  input  logic               dirty1,
  output logic               load_data0,
  output logic               load_data1,
  output logic               load_tag0,
  output logic               load_tag1,
  output logic               load_valid0,
  output logic               load_valid1,
  output logic               load_dirty0,
  output logic               load_dirty1,
  output logic               dirty_in,
  output logic               data_sel,
  output logic               pmem_addr_sel,
  output logic               way_sel,
  output logic               pmem_read,
  output logic               pmem_write,
  input  logic               pmem_resp
);

  cache_ctrl_state_t state;
  logic              victim;
  logic              lru_way;
  logic              lru_load;
  logic              lru_value;
  logic              req;
  logic              hit_now;
  logic              victim_dirty;
  logic [1:0]        ld_data, ld_tag, ld_valid, ld_dirty;

  assign req          = mem_read | mem_write;
  assign hit_now      = req & hit & (compare0 | compare1);
  assign victim_dirty = lru_way ? (valid1 & dirty1) : (valid0 & dirty0);

  cache_lru #(.SETS(NUM_SETS)) u_lru (
    .clk   (clk),
    .rst   (rst),
    .index (index),
    .load  (lru_load),
    .value (lru_value),
    .lru   (lru_way)
  );

  // The victim is latched on the miss so a changing index cannot redirect the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            victim <= lru_way;
            state  <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (pmem_resp) state <= ALLOCATE;
        ALLOCATE:  if (pmem_resp) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Hit response is Mealy; everything is forced low while reset is held.
  always_comb begin
    mem_resp      = 1'b0;
    ld_data       = 2'b00;
    ld_tag        = 2'b00;
    ld_valid      = 2'b00;
    ld_dirty      = 2'b00;
    dirty_in      = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    lru_load      = 1'b0;
    lru_value     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (hit_now) begin
            mem_resp  = 1'b1;
            way_sel   = compare1;
            lru_load  = 1'b1;
            lru_value = ~compare1;
            if (mem_write) begin
              ld_data[compare1]  = 1'b1;
              ld_dirty[compare1] = 1'b1;
              dirty_in           = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          data_sel  = 1'b1;
          way_sel   = victim;
          if (pmem_resp) begin
            ld_data[victim]  = 1'b1;
            ld_tag[victim]   = 1'b1;
            ld_valid[victim] = 1'b1;
            ld_dirty[victim] = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign {load_data1, load_data0}   = ld_data;
  assign {load_tag1, load_tag0}     = ld_tag;
  assign {load_valid1, load_valid0} = ld_valid;
  assign {load_dirty1, load_dirty0} = ld_dirty;

endmodule
